// File: rtl/alu_issue_wb_if.sv
// Bundle of the instruction, ALU, writeback, status and debug signals of the
// decode/issue/writeback stage. The master side is the environment (the
// instruction source plus the ALU). The slave side is the stage itself.
interface alu_issue_wb_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  logic [3:0]       alu_codop;
  logic [15:0]      alu_data_a;
  logic [15:0]      alu_data_b;
  logic [15:0]      alu_out;
  logic             alu_neg;
  logic             alu_zero;
  logic             alu_overflow;
  logic             wb_valid;
  logic [3:0]       wb_rd;
  logic [15:0]      wb_data;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic [CNT_W-1:0] retired_count;
  logic [3:0]       dbg_addr;
  logic [15:0]      dbg_data;

  modport master (
    output instr_valid, instr, alu_out, alu_neg, alu_zero, alu_overflow, dbg_addr,
    input  instr_ready, alu_codop, alu_data_a, alu_data_b, wb_valid, wb_rd, wb_data,
           flag_n, flag_z, flag_v, retired_count, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_out, alu_neg, alu_zero, alu_overflow, dbg_addr,
    output instr_ready, alu_codop, alu_data_a, alu_data_b, wb_valid, wb_rd, wb_data,
           flag_n, flag_z, flag_v, retired_count, dbg_data
  );
endinterface

// File: rtl/alu_issue_wb.sv
// Decode, operand issue and writeback around an external registered 16-bit ALU.
// D holds the instruction whose operands are being presented to the ALU. W holds
// the instruction whose result is on alu_out. Forwarding from W into D lets
// dependent instructions issue back-to-back without stalling.
module alu_issue_wb #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_issue_wb_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLTI = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_ORI  = 4'd7;
  localparam logic [3:0] OP_XORI = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_SUBI = 4'd10;

  // The ALU's default case produces zero for this code, so it doubles as "idle".
  localparam logic [3:0] CODOP_IDLE = 4'd15;

  // Architectural state
  logic [15:0]      regs_q [NREGS];
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // D stage
  logic             d_v_q, d_v_d;
  logic [15:0]      d_instr_q, d_instr_d;

  // W stage
  logic             w_v_q, w_v_d;
  logic             w_we_q, w_we_d;
  logic [3:0]       w_rd_q, w_rd_d;
  logic             w_ov_q, w_ov_d;

  logic [3:0]  d_op, d_rd, d_rs, d_rt;
  logic        d_is_r, d_is_i, d_we;
  logic        w_fwd_en;
  logic [15:0] rs_val, rt_val;
  logic [3:0]  codop;
  logic [15:0] data_a, data_b;
  logic        commit;
  logic        wb_en;
  logic        accept;

  assign d_op = d_instr_q[15:12];
  assign d_rd = d_instr_q[11:8];
  assign d_rs = d_instr_q[7:4];
  assign d_rt = d_instr_q[3:0];

  // Classify the instruction held in D; anything outside both classes is a NOP.
  always_comb begin
    d_is_r = 1'b0;
    d_is_i = 1'b0;
    case (d_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:                d_is_r = 1'b1;
      OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI: d_is_i = 1'b1;
      default: ;
    endcase
  end

  assign d_we = d_is_r | d_is_i;

  // W's result is still on alu_out and not yet in the register file.
  assign w_fwd_en = w_v_q & w_we_q;

  // Source read with R0 hard-wired to zero and bypass from W.
  always_comb begin
    rs_val = 16'd0;
    if (d_rs != 4'd0) begin
      if (w_fwd_en && (w_rd_q == d_rs)) rs_val = bus.alu_out;
      else                              rs_val = regs_q[d_rs];
    end
  end

  // Second source read, same rules as the first.
  always_comb begin
    rt_val = 16'd0;
    if (d_rt != 4'd0) begin
      if (w_fwd_en && (w_rd_q == d_rt)) rt_val = bus.alu_out;
      else                              rt_val = regs_q[d_rt];
    end
  end

  // ALU drive: R-type feeds rt on port a, so the ALU's sub yields rs - rt.
  always_comb begin
    codop  = CODOP_IDLE;
    data_a = 16'd0;
    data_b = 16'd0;
    if (d_v_q) begin
      codop = d_op;
      if (d_is_r) begin
        data_a = rt_val;
        data_b = rs_val;
      end else if (d_is_i) begin
        data_a = rs_val;
        data_b = {12'd0, d_rt};
      end
    end
  end

  assign bus.alu_codop  = codop;
  assign bus.alu_data_a = data_a;
  assign bus.alu_data_b = data_b;

  // No stalls: the stage is ready whenever reset is released.
  assign bus.instr_ready = ~rst;
  assign accept          = bus.instr_valid;

  // Next state of D and W.
  always_comb begin
    d_v_d     = accept;
    d_instr_d = accept ? bus.instr : d_instr_q;
    w_v_d     = d_v_q;
    w_we_d    = d_v_q & d_we;
    w_rd_d    = d_rd;
    w_ov_d    = bus.alu_overflow;
  end

  // Writes to R0 are dropped, but flags and the counter still update for it.
  assign commit = w_v_q & w_we_q;
  assign wb_en  = commit & (w_rd_q != 4'd0);

  assign bus.wb_valid = wb_en;
  assign bus.wb_rd    = w_rd_q;
  assign bus.wb_data  = bus.alu_out;

  // Next state of the status flags and retired counter.
  always_comb begin
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    cnt_d    = cnt_q;
    if (commit) begin
      flag_n_d = bus.alu_neg;
      flag_z_d = bus.alu_zero;
      flag_v_d = w_ov_q;
      cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_v_q     <= 1'b0;
      d_instr_q <= 16'd0;
      w_v_q     <= 1'b0;
      w_we_q    <= 1'b0;
      w_rd_q    <= 4'd0;
      w_ov_q    <= 1'b0;
    end else begin
      d_v_q     <= d_v_d;
      d_instr_q <= d_instr_d;
      w_v_q     <= w_v_d;
      w_we_q    <= w_we_d;
      w_rd_q    <= w_rd_d;
      w_ov_q    <= w_ov_d;
    end
  end

  // Committed flags and retired-instruction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      cnt_q    <= cnt_d;
    end
  end

  // Register file write port, fed straight from the ALU output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 16'd0;
    end else if (wb_en) begin
      regs_q[w_rd_q] <= bus.alu_out;
    end
  end

  assign bus.flag_n        = flag_n_q;
  assign bus.flag_z        = flag_z_q;
  assign bus.flag_v        = flag_v_q;
  assign bus.retired_count = cnt_q;

  // Debug port sees only committed register contents.
  assign bus.dbg_data = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: a simple registered ALU model closes the loop, and an
// in-order architectural model predicts operands, writebacks and commits.
module tb_alu_issue_wb;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  alu_issue_wb_if #(.CNT_W(16)) bus ();

  alu_issue_wb #(.NREGS(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- external ALU model ----------------
  function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (c)
      4'd0, 4'd9: r = a + b;
      4'd1:       r = b - a;
      4'd2:       r = (a > b) ? 16'd1 : 16'd0;
      4'd3, 4'd6: r = a & b;
      4'd4, 4'd7: r = a | b;
      4'd5, 4'd8: r = a ^ b;
      4'd10:      r = a - b;
      default:    r = 16'd0;
    endcase
    return r;
  endfunction

  function automatic logic alu_ov_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd0, 4'd9: return s[16];
      4'd1:       return a > b;
      4'd10:      return b > a;
      default:    return 1'b0;
    endcase
  endfunction

  logic [15:0] alu_q;
  always @(posedge clk or posedge rst) begin
    if (rst) alu_q <= 16'd0;
    else     alu_q <= alu_f(bus.alu_codop, bus.alu_data_a, bus.alu_data_b);
  end

  assign bus.alu_out      = alu_q;
  assign bus.alu_neg      = alu_q[15];
  assign bus.alu_zero     = (alu_q == 16'd0);
  assign bus.alu_overflow = alu_ov_f(bus.alu_codop, bus.alu_data_a, bus.alu_data_b);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [3:0]  codop;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
    logic        n;
    logic        z;
    logic        ov;
  } ent_t;

  ent_t        ent [MAXC];
  logic [15:0] ra [16];   // program-order register values
  logic [15:0] rv [16];   // committed register values
  logic        mfn, mfz, mfv;
  logic [15:0] mcnt;
  int          committed_upto = 0;
  logic [15:0] seen_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) ent[i] = '0;
    for (int i = 0; i < 16; i++) begin
      ra[i] = 16'd0;
      rv[i] = 16'd0;
    end
    mfn = 1'b0; mfz = 1'b0; mfv = 1'b0;
    mcnt = 16'd0;
  endtask

  task automatic model_accept(input int e, input logic [15:0] ins);
    ent_t        x;
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] sv, tv, imm, res;
    logic        ov;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    sv = ra[rs]; tv = ra[rt]; imm = {12'd0, rt};
    res = 16'd0; ov = 1'b0;
    x = '0;
    x.v = 1'b1; x.codop = op; x.rd = rd; x.we = (op <= 4'd10);
    case (op)
      4'd0:  begin x.a = tv; x.b = sv; {ov, res} = {1'b0, sv} + {1'b0, tv}; end
      4'd1:  begin x.a = tv; x.b = sv; res = sv - tv; ov = (tv > sv); end
      4'd3:  begin x.a = tv; x.b = sv; res = sv & tv; end
      4'd4:  begin x.a = tv; x.b = sv; res = sv | tv; end
      4'd5:  begin x.a = tv; x.b = sv; res = sv ^ tv; end
      4'd2:  begin x.a = sv; x.b = imm; res = (sv > imm) ? 16'd1 : 16'd0; end
      4'd6:  begin x.a = sv; x.b = imm; res = sv & imm; end
      4'd7:  begin x.a = sv; x.b = imm; res = sv | imm; end
      4'd8:  begin x.a = sv; x.b = imm; res = sv ^ imm; end
      4'd9:  begin x.a = sv; x.b = imm; {ov, res} = {1'b0, sv} + {1'b0, imm}; end
      4'd10: begin x.a = sv; x.b = imm; res = sv - imm; ov = (imm > sv); end
      default: ;
    endcase
    x.data = res; x.n = res[15]; x.z = (res == 16'd0); x.ov = ov;
    if (x.we && rd != 4'd0) ra[rd] = res;
    ent[e] = x;
  endtask

  task automatic model_commit(input int i);
    if (ent[i].v && ent[i].we) begin
      if (ent[i].rd != 4'd0) rv[ent[i].rd] = ent[i].data;
      mfn = ent[i].n; mfz = ent[i].z; mfv = ent[i].ov;
      mcnt = mcnt + 16'd1;
    end
  endtask

  // One clock: present an instruction, then check everything at the falling edge.
  task automatic step(input logic v, input logic [15:0] ins);
    int         e;
    ent_t       x, w;
    logic [3:0] da;
    logic       exp_wb;
    da = 4'($urandom_range(0, 15));
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.dbg_addr    = da;
    @(posedge clk);
    @(negedge clk);
    e = cyc;
    if (e >= MAXC) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", e, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (v) model_accept(e, ins);
    for (int i = committed_upto + 1; i <= e - 2; i++) model_commit(i);
    if (e - 2 > committed_upto) committed_upto = e - 2;
    x = ent[e];
    w = ent[e - 1];
    seen_a = bus.alu_data_a;
    chk("ready", 32'(bus.instr_ready), 32'(1));
    chk("codop", 32'(bus.alu_codop), 32'(x.v ? x.codop : 4'd15));
    chk("data_a", 32'(bus.alu_data_a), 32'(x.v ? x.a : 16'd0));
    chk("data_b", 32'(bus.alu_data_b), 32'(x.v ? x.b : 16'd0));
    exp_wb = w.v & w.we & (w.rd != 4'd0);
    chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wb));
    if (exp_wb) begin
      chk("wb_rd", 32'(bus.wb_rd), 32'(w.rd));
      chk("wb_data", 32'(bus.wb_data), 32'(w.data));
    end
    chk("flag_n", 32'(bus.flag_n), 32'(mfn));
    chk("flag_z", 32'(bus.flag_z), 32'(mfz));
    chk("flag_v", 32'(bus.flag_v), 32'(mfv));
    chk("count", 32'(bus.retired_count), 32'(mcnt));
    chk("dbg_data", 32'(bus.dbg_data), 32'(rv[da]));
    bus.instr_valid = 1'b0;
  endtask

  task automatic flush();
    step(1'b0, 16'd0);
    step(1'b0, 16'd0);
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] r, input logic [15:0] v);
    @(negedge clk);
    bus.dbg_addr = r;
    #1;
    chk(tag, 32'(bus.dbg_data), 32'(v));
  endtask

  // Asynchronous reset asserted between clock edges, with outputs checked at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
    chk("rst_codop", 32'(bus.alu_codop), 32'(15));
    chk("rst_data_a", 32'(bus.alu_data_a), 32'(0));
    chk("rst_data_b", 32'(bus.alu_data_b), 32'(0));
    chk("rst_flags", 32'({bus.flag_n, bus.flag_z, bus.flag_v}), 32'(0));
    chk("rst_count", 32'(bus.retired_count), 32'(0));
    chk("rst_ready", 32'(bus.instr_ready), 32'(0));
    for (int i = 1; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      chk("rst_reg", 32'(bus.dbg_data), 32'(0));
      chk("rst_no_wb", 32'(bus.wb_valid), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    committed_upto = cyc;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 16'd0;
    bus.dbg_addr    = 4'd0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Immediates then a register subtract: r3 = r1 - r2
    step(1'b1, enc(9, 1, 0, 5));
    step(1'b1, enc(9, 2, 0, 3));
    step(1'b1, enc(1, 3, 1, 2));
    flush();
    expect_reg("imm_r3", 4'd3, 16'd2);
    chk("imm_fz", 32'(bus.flag_z), 32'(0));
    chk("imm_fn", 32'(bus.flag_n), 32'(0));
    chk("imm_count", 32'(bus.retired_count), 32'(3));

    // Back-to-back dependency through the bypass
    step(1'b1, enc(9, 1, 0, 15));
    chk("b2b_a0", 32'(seen_a), 32'(0));
    step(1'b1, enc(9, 1, 1, 15));
    chk("b2b_a1", 32'(seen_a), 32'(15));
    step(1'b1, enc(9, 1, 1, 15));
    chk("b2b_a2", 32'(seen_a), 32'(30));
    flush();
    expect_reg("b2b_r1", 4'd1, 16'd45);

    // Carry out of addi
    step(1'b1, enc(10, 1, 0, 1));
    step(1'b1, enc(9, 2, 1, 1));
    flush();
    expect_reg("ov_r1", 4'd1, 16'hFFFF);
    expect_reg("ov_r2", 4'd2, 16'h0000);
    chk("ov_flags_nzv", 32'({bus.flag_n, bus.flag_z, bus.flag_v}), 32'(3'b011));

    // R0 is read-only, NOPs are invisible
    step(1'b1, enc(9, 0, 0, 7));
    step(1'b1, enc(12, 3, 1, 2));
    chk("nop_no_wb", 32'(bus.wb_valid), 32'(0));
    step(1'b1, enc(10, 4, 0, 1));
    chk("nop_no_wb2", 32'(bus.wb_valid), 32'(0));
    flush();
    expect_reg("r0_zero", 4'd0, 16'd0);
    expect_reg("r0_r4", 4'd4, 16'hFFFF);
    chk("r0_fn", 32'(bus.flag_n), 32'(1));
    chk("r0_count", 32'(bus.retired_count), 32'(10));

    // Bubbles interleaved with slti
    step(1'b1, enc(9, 1, 0, 9));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, enc(2, 5, 1, 4));
      step(1'b0, enc(2, 5, 1, 4));
    end
    flush();
    expect_reg("slti_r5", 4'd5, 16'd1);
    chk("slti_count", 32'(bus.retired_count), 32'(15));

    // Reset with instructions sitting in D and W
    step(1'b1, enc(9, 6, 0, 3));
    step(1'b1, enc(9, 7, 6, 2));
    do_reset();
    flush();
    expect_reg("post_rst_r6", 4'd6, 16'd0);
    expect_reg("post_rst_r7", 4'd7, 16'd0);

    // Randomized traffic with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step(($urandom_range(0, 3) != 0),
           enc($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15)));
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
